// File: rtl/spart_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spart_bus_responder
//  Brief    : SPART bus-side responder: register decode, baud generator,
//             one-byte RX buffer and one-byte TX holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module spart_bus_responder #(
    parameter logic [15:0] DEFAULT_DIV = 16'h0145
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       brg_en,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    typedef enum logic [0:0] {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_t;

    localparam logic [1:0] c_ADDR_DATA   = 2'b00;
    localparam logic [1:0] c_ADDR_STATUS = 2'b01;
    localparam logic [1:0] c_ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] c_ADDR_DIV_HI = 2'b11;

    logic        w_rd_data;
    logic        w_rd_stat;
    logic        w_wr_data;
    logic        w_wr_div_lo;
    logic        w_wr_div_hi;
    logic [7:0]  w_status;

    logic [7:0]  r_div_lo;
    logic [7:0]  r_div_hi;
    logic [15:0] r_brg_cnt;
    logic        r_brg_en;

    logic [7:0]  r_rx_buf;
    logic        r_rda;
    logic        r_ovr;

    logic [7:0]  r_hold;
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;
    logic        w_tx_load;

    assign w_rd_data   = iocs &  iorw & (ioaddr == c_ADDR_DATA);
    assign w_rd_stat   = iocs &  iorw & (ioaddr == c_ADDR_STATUS);
    assign w_wr_data   = iocs & ~iorw & (ioaddr == c_ADDR_DATA);
    // Divisor registers are write-only and accept a write regardless of iorw
    assign w_wr_div_lo = iocs & (ioaddr == c_ADDR_DIV_LO);
    assign w_wr_div_hi = iocs & (ioaddr == c_ADDR_DIV_HI);

    assign w_status = {5'b0_0000, r_ovr, tbr, r_rda};

    assign databus = (rst_n && w_rd_data) ? r_rx_buf :
                     (rst_n && w_rd_stat) ? w_status : 8'hzz;

    // ---------------- baud generator ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_lo  <= DEFAULT_DIV[7:0];
            r_div_hi  <= DEFAULT_DIV[15:8];
            r_brg_cnt <= DEFAULT_DIV;
            r_brg_en  <= 1'b0;
        end else begin
            if (w_wr_div_lo) begin
                r_div_lo <= databus;
            end
            if (w_wr_div_hi) begin
                r_div_hi  <= databus;
                r_brg_cnt <= {databus, r_div_lo};
                r_brg_en  <= 1'b0;
            end else if (r_brg_cnt <= 16'd1) begin
                // Divisor 0 or 1 keeps the count pinned here: tick every cycle
                r_brg_en  <= 1'b1;
                r_brg_cnt <= {r_div_hi, r_div_lo};
            end else begin
                r_brg_en  <= 1'b0;
                r_brg_cnt <= r_brg_cnt - 16'd1;
            end
        end
    end

    assign brg_en = r_brg_en;

    // ---------------- receive buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_buf <= 8'h00;
            r_rda    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_rd_stat) begin
                r_ovr <= 1'b0;
            end
            if (rx_valid) begin
                // A read in the same cycle frees the buffer for the new byte
                if (!r_rda || w_rd_data) begin
                    r_rx_buf <= rx_data;
                    r_rda    <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_rd_data) begin
                r_rda <= 1'b0;
            end
        end
    end

    assign rda = r_rda;

    // ---------------- transmit holding register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_EMPTY;
            r_hold     <= 8'h00;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_wr_data && (r_tx_state == TX_EMPTY)) begin
                r_hold <= databus;
            end
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_load = 1'b0;
        case (r_tx_state)
            TX_EMPTY: begin
                if (w_wr_data) begin
                    w_tx_next = TX_FULL;
                end
            end
            TX_FULL: begin
                if (!tx_busy) begin
                    w_tx_load = 1'b1;
                    w_tx_next = TX_EMPTY;
                end
            end
            default: w_tx_next = TX_EMPTY;
        endcase
    end

    assign tbr     = (r_tx_state == TX_EMPTY);
    assign tx_load = w_tx_load;
    assign tx_data = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_bus_responder
//  Brief    : Scoreboard bench for spart_bus_responder with reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spart_bus_responder;

    localparam logic [15:0] DEFAULT_DIV = 16'h0145;

    logic       clk;
    logic       rst_n;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       brg_en;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [7:0] bus_drv;
    logic       bus_oe;
    assign databus = bus_oe ? bus_drv : 8'hzz;

    spart_bus_responder #(.DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .brg_en(brg_en),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    // reference model state
    logic [7:0] m_buf, m_hold;
    bit         m_rda, m_ovr, m_tbr;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf = 8'h00; m_hold = 8'h00;
        m_rda = 0; m_ovr = 0; m_tbr = 1;
    endtask

    // One bus cycle: drive inputs, push expected responses, advance one clock
    task automatic step(input bit cs, input bit rw, input logic [1:0] a, input logic [7:0] wd,
                        input bit rv, input logic [7:0] rd, input bit busy);
        bit rdd, rds, wrd, n_tbr;
        rdd = cs && rw && (a == 2'b00);
        rds = cs && rw && (a == 2'b01);
        wrd = cs && !rw && (a == 2'b00);
        iocs = cs; iorw = rw; ioaddr = a; bus_drv = wd;
        bus_oe = cs && !(rw && (a[1] == 1'b0));
        rx_valid = rv; rx_data = rd; tx_busy = busy;

        if (rdd) rd_q.push_back(m_buf);
        if (rds) rd_q.push_back({5'b0, m_ovr, m_tbr, m_rda});
        n_tbr = m_tbr;
        if (!m_tbr && !busy) begin
            tx_q.push_back(m_hold);
            n_tbr = 1;
        end else if (m_tbr && wrd) begin
            m_hold = wd;
            n_tbr = 0;
        end
        if (rds) m_ovr = 0;
        if (rv) begin
            if (!m_rda || rdd) begin
                m_buf = rd;
                m_rda = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (rdd) begin
            m_rda = 0;
        end
        m_tbr = n_tbr;

        @(posedge clk);
        #1;
        iocs = 0; iorw = 0; rx_valid = 0; bus_oe = 0;
        chk("rda", int'(rda), int'(m_rda));
        chk("tbr", int'(tbr), int'(m_tbr));
    endtask

    task automatic idle(input bit busy);
        step(0, 0, 2'b00, 8'h00, 0, 8'h00, busy);
    endtask

    task automatic measure_period(input string nm, input int exp);
        int n;
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = brg_en;
        end
        n = 0;
        if (seen) begin
            seen = 0;
            for (int i = 1; i < 3000 && !seen; i++) begin
                @(negedge clk);
                n = i;
                seen = brg_en;
            end
        end
        if (!seen) n = -1;
        chk(nm, n, exp);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data or a tx_load
    always @(negedge clk) begin
        if (rst_n) begin
            if (iocs && iorw && (ioaddr[1] == 1'b0)) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", int'(databus), int'(rd_q.pop_front()));
            end
            if (tx_load) begin
                if (tx_q.size() == 0) chk("tx_load_unexpected", 1, 0);
                else chk("tx_data", int'(tx_data), int'(tx_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 0; iocs = 0; iorw = 0; ioaddr = 0; bus_drv = 0; bus_oe = 0;
        tx_busy = 0; rx_data = 0; rx_valid = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rda", int'(rda), 0);
        chk("reset_tbr", int'(tbr), 1);
        chk("reset_tx_load", int'(tx_load), 0);
        chk("reset_brg_en", int'(brg_en), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0);                 // status = 02
        measure_period("brg_default", int'(DEFAULT_DIV));

        // divisor writes with iorw=1
        step(1, 1, 2'b10, 8'h04, 0, 8'h00, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h00, 0);
        measure_period("brg_div4", 4);
        measure_period("brg_div4_again", 4);

        // RX single byte
        step(0, 0, 2'b00, 8'h00, 1, 8'hA5, 0);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 0);

        // overrun
        step(0, 0, 2'b00, 8'h00, 1, 8'h11, 0);
        step(0, 0, 2'b00, 8'h00, 1, 8'h22, 0);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 0);
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0);
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0);

        // TX with busy engine; second write while full is ignored
        step(1, 0, 2'b00, 8'h3C, 0, 8'h00, 1);
        step(1, 0, 2'b00, 8'h55, 0, 8'h00, 1);
        idle(1);
        idle(0);
        idle(0);

        // same-cycle read and receive
        step(0, 0, 2'b00, 8'h00, 1, 8'h66, 0);
        step(1, 1, 2'b00, 8'h00, 1, 8'h77, 0);
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), 8'($urandom),
                 ($urandom % 3) == 0, 8'($urandom), ($urandom % 3) == 0);
        end

        // reset mid-traffic with buffered bytes on both sides
        step(0, 0, 2'b00, 8'h00, 1, 8'h5A, 1);
        idle(1);
        if (m_tbr) step(1, 0, 2'b00, 8'h99, 0, 8'h00, 1);
        #2;
        rst_n = 0;
        #2;
        chk("midreset_rda", int'(rda), 0);
        chk("midreset_tbr", int'(tbr), 1);
        chk("midreset_tx_load", int'(tx_load), 0);
        tx_busy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 0);
        measure_period("brg_after_reset", int'(DEFAULT_DIV));

        idle(0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
